// File: rtl/serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
// Holds the FSM state encoding and the step/counter sizing functions.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned calc_steps(input int unsigned width,
                                             input int unsigned digit);
    return width / digit;
  endfunction

  // A single-step configuration still needs a 1-bit counter.
  function automatic int unsigned calc_cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] In_A;
  logic [WIDTH-1:0] In_B;
  logic             Borrow_in;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Difference;
  logic             Borrow_out;
  logic             Overflow;

  modport master (
    output In_Valid, In_A, In_B, Borrow_in, Out_Ready,
    input  In_Ready, Out_Valid, Difference, Borrow_out, Overflow
  );

  modport slave (
    input  In_Valid, In_A, In_B, Borrow_in, Out_Ready,
    output In_Ready, Out_Valid, Difference, Borrow_out, Overflow
  );

endinterface

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit ripple chain of full-subtractor cells.
// Also exposes the borrow entering the top cell for signed-overflow detection.
module digit_subtractor #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_borrow,
  output logic [DIGIT-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_top_borrow
);

  logic [DIGIT:0] w_borrow;

  assign w_borrow[0] = i_borrow;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    assign o_diff[i]     = i_a[i] ^ i_b[i] ^ w_borrow[i];
    assign w_borrow[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_borrow[i]);
  end

  assign o_borrow     = w_borrow[DIGIT];
  assign o_top_borrow = w_borrow[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Difference = In_A - In_B - Borrow_in, DIGIT bits per clock,
// with valid/ready handshakes, unsigned borrow-out and signed-overflow flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned Steps = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CntW  = calc_cnt_width(Steps);
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_shift;
  logic             r_borrow;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_overflow;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_cell_diff;
  logic             w_cell_borrow;
  logic             w_top_borrow;
  logic [WIDTH-1:0] w_shift_next;

  digit_subtractor #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a          (r_a[DIGIT-1:0]),
    .i_b          (r_b[DIGIT-1:0]),
    .i_borrow     (r_borrow),
    .o_diff       (w_cell_diff),
    .o_borrow     (w_cell_borrow),
    .o_top_borrow (w_top_borrow)
  );

  // Gated by reset so the producer never sees ready while the block is held in reset.
  assign w_in_ready = (r_state == StIdle) & rst_i;
  assign w_accept   = bus.In_Valid & w_in_ready;
  assign w_last     = (r_state == StRun) && (r_cnt == LastCnt);

  // New digit enters at the top; after Steps shifts the LSB digit lands at bit 0.
  assign w_shift_next = (r_shift >> DIGIT) | (WIDTH'(w_cell_diff) << (WIDTH - DIGIT));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept)      w_state_next = StRun;
      StRun:   if (w_last)        w_state_next = StDone;
      StDone:  if (bus.Out_Ready) w_state_next = StIdle;
      default:                    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_shift      <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.In_A;
      r_b      <= bus.In_B;
      r_borrow <= bus.Borrow_in;
      r_cnt    <= '0;
    end else if (r_state == StRun) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_shift  <= w_shift_next;
      r_borrow <= w_cell_borrow;
      r_cnt    <= r_cnt + 1'b1;
      // Result outputs only move on the step that enters DONE.
      if (w_last) begin
        r_diff       <= w_shift_next;
        r_borrow_out <= w_cell_borrow;
        r_overflow   <= w_top_borrow ^ w_cell_borrow;
      end
    end
  end

  assign bus.In_Ready   = w_in_ready;
  assign bus.Out_Valid  = (r_state == StDone);
  assign bus.Difference = r_diff;
  assign bus.Borrow_out = r_borrow_out;
  assign bus.Overflow   = r_overflow;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, parametrised subtractor computing Difference = In_A − In_B − Borrow_in over WIDTH bits, DIGIT bits per clock. It is built from a chain of full-subtractor bit cells, with the borrow held in a register between cycles. Valid/ready handshakes on input and output let the ALU datapath issue operands and stall on the result. It also reports the unsigned borrow-out and a signed-overflow flag.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2.
DIGIT, 2, bits processed per cycle; must divide WIDTH; DIGIT = WIDTH gives a single RUN cycle.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  reset, asynchronous, active-low.
In_Valid  input  1  operands present.
In_Ready  output  1  block can accept operands.
In_A  input  WIDTH  minuend.
In_B  input  WIDTH  subtrahend.
Borrow_in  input  1  initial borrow.
Out_Valid  output  1  result available.
Out_Ready  input  1  consumer takes the result.
Difference  output  WIDTH  In_A − In_B − Borrow_in, modulo 2^WIDTH.
Borrow_out  output  1  unsigned borrow from the MSB (1 when In_A < In_B + Borrow_in).
Overflow  output  1  signed overflow: borrow into MSB cell XOR borrow out of MSB cell.

Behaviour:
- STEPS = WIDTH/DIGIT. FSM states: IDLE, RUN, DONE.
- Reset (rst_i low, asynchronous) → IDLE, step counter 0, borrow register 0, shift registers 0.
- Outputs while in reset: In_Ready 0, Out_Valid 0, Difference 0, Borrow_out 0, Overflow 0.
- In_Ready = (state == IDLE). Out_Valid = (state == DONE).
- IDLE: on In_Valid & In_Ready, latch In_A, In_B and Borrow_in into working registers, clear the counter, go to RUN. Input data is ignored at every other time.
- RUN, each cycle:
  - the digit cell subtracts the low DIGIT bits of A and B, using the borrow register as input borrow;
  - the DIGIT result bits shift in at the top of the result register; A and B shift right by DIGIT;
  - the borrow register takes the cell's borrow-out; the counter increments.
- On the last step (counter = STEPS−1): capture Overflow from the MSB cell's borrow-in and borrow-out, then go to DONE.
- Latency: Out_Valid rises exactly STEPS cycles after the accepting edge.
- DONE: Difference, Borrow_out and Overflow stay constant until Out_Ready is seen high. On that edge go to IDLE; In_Ready rises on the following cycle. There is no same-cycle result/accept overlap, so sustained throughput is one operation per STEPS+2 cycles.
- Out_Ready while not in DONE is ignored. In_Valid while not in IDLE is ignored and need not be held stable.
- Result outputs change only on the transition into DONE; they hold their last value in IDLE and RUN.
- Reset asserted mid-RUN or in DONE aborts the operation immediately; no result is produced.
- Wrap-around: the result is modulo 2^WIDTH; Borrow_out reports the wrap.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a localparam helper for STEPS and the counter width (clog2(STEPS), minimum 1).
- One sub-module, digit_subtractor: combinational DIGIT-bit ripple chain of full-subtractor cells.
  - Inputs: A, B, borrow-in.
  - Outputs: DIGIT-bit difference, borrow-out, and the borrow into its top cell (used for Overflow).

Test Plan:
- WIDTH=8, DIGIT=2: A=0x05, B=0x03, Bin=0 → Difference 0x02, Borrow_out 0, Overflow 0; Out_Valid exactly 4 cycles after accept.
- A=0x03, B=0x05, Bin=0 → 0xFE, Borrow_out 1, Overflow 0. A=0x00, B=0x00, Bin=1 → 0xFF, Borrow_out 1, Overflow 0.
- A=0x80, B=0x01, Bin=0 → 0x7F, Borrow_out 0, Overflow 1. A=0x7F, B=0xFF, Bin=0 → 0x80, Borrow_out 1, Overflow 1.
- Backpressure: hold Out_Ready=0 for 5 cycles in DONE → outputs stable, In_Ready 0, new In_Valid ignored. Then Out_Ready=1 → IDLE, and In_Ready goes high the next cycle.
- Reset mid-RUN: drop rst_i after 2 RUN cycles → all outputs 0 asynchronously. After release, In_Ready=1; the next operation 0x10−0x01 → 0x0F.
- DIGIT=8 (single step) and DIGIT=1 (8 steps): random 1000-vector sweep vs. reference model, with latency checked as STEPS.
